periph_launch_ctrl: RTL and testbench
=====================================

// Module: periph_launch_ctrl
// PURPOSE
//  Sequences the CCD and neural accelerator from the CPU status-register handshake bits (reg15: CCD_en/CCD_done, ACC_en/ACC_done).
//  Converts level requests into single-cycle start pulses and waits for completion pulses.
//  Owns the shared frame buffer and grants it to exactly one peripheral at a time.
//  Sits between fetchdecode (reg15 bits) and the CCD / accelerator blocks.
// PARAMETERS
//  TMO_W    20       width of the watchdog counter
//  TMO_CYC  1000000  cycles in a WAIT state before the timeout fires; must be < 2**TMO_W
// PORTS
//  clk        in   1   single clock, all logic on posedge
//  rst        in   1   asynchronous, active-high reset
//  iCCD_en    in   1   CPU request level for a CCD capture (reg15[1])
//  iACC_en    in   1   CPU request level for an accelerator run (reg15[3])
//  oCCD_done  out  1   completion level to reg15[0]
//  oACC_done  out  1   completion level to reg15[2]
//  oCCD_start out  1   1-cycle start pulse to CCD
//  iCCD_fin   in   1   1-cycle finish pulse from CCD
//  oACC_start out  1   1-cycle start pulse to accelerator
//  iACC_fin   in   1   1-cycle finish pulse from accelerator
//  oBufOwner  out  2   shared-buffer grant: 00 none, 01 CCD, 10 ACC; 11 never driven
//  oErr       out  1   sticky timeout flag
//  iErrClr    in   1   clears oErr; takes priority over a same-cycle set
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, watchdog=0; rst may assert in any state and aborts immediately.
//  All outputs are registered; no combinational input->output path.
//  FSM states: IDLE, C_START, C_WAIT, C_DONE, A_START, A_WAIT, A_DONE.
//  IDLE:
//   - iCCD_en=1 -> C_START; else iACC_en=1 -> A_START.
//   - Both high in the same cycle -> CCD first (capture precedes compute).
//  x_START (1 cycle):
//   - start pulse =1; oBufOwner = owner.
//   - Watchdog cleared; -> x_WAIT.
//  x_WAIT:
//   - oBufOwner held; watchdog increments each cycle.
//   - fin=1 -> x_DONE if en still 1, else IDLE.
//   - Watchdog == TMO_CYC-1 without fin -> oErr<=1, same transition as fin (CPU never hangs).
//   - fin and timeout in the same cycle -> fin wins; oErr is not set.
//   - en dropping mid-WAIT does not abort: the peripheral cannot be cancelled, so the block keeps waiting for fin/timeout.
//  x_DONE:
//   - done=1 and oBufOwner=00 (buffer released on entry).
//   - Stays while en=1; en=0 -> IDLE with done=0 the next cycle (4-phase handshake).
//  The other peripheral's en is ignored until IDLE; it is then serviced with no further CPU action.
//  fin pulses outside the matching WAIT state are ignored (no state change, no flag).
//  Latency:
//   - en rise -> start pulse: 2 cycles.
//   - fin -> done high: 1 cycle.
//   - en fall -> done low: 1 cycle.
//  Watchdog: unsigned TMO_W bits, saturating; only counts in WAIT states.
// STRUCTURE
//  periph_pkg: state enum (typedef enum logic[2:0]), BUF_NONE/BUF_CCD/BUF_ACC constants.
//  One sub-module, wd_counter (clear, enable, TMO_W, terminal-count flag).
//  FSM and output registers are in periph_launch_ctrl.
// TESTING
//  1. Reset, then iCCD_en=1 at cycle 0:
//     -> oCCD_start high only in cycle 2; oBufOwner=01 from cycle 2.
//     -> iCCD_fin at cycle 10: oCCD_done=1 and owner=00 at cycle 11.
//     -> en=0 at 15: done=0 at 16.
//  2. iCCD_en and iACC_en rise together:
//     -> CCD serviced first.
//     -> After CCD en drops, oACC_start pulses 2 cycles after IDLE; owner never 11.
//  3. TMO_CYC=16, iACC_en=1, no fin:
//     -> oErr=1 and oACC_done=1 at 16 cycles after A_WAIT entry.
//     -> iErrClr pulse clears oErr.
//  4. fin asserted on the exact timeout cycle -> done=1, oErr stays 0.
//  5. iCCD_en dropped mid-C_WAIT, fin later -> FSM returns to IDLE; oCCD_done never asserts.
//  6. rst pulsed during A_WAIT:
//     -> All outputs 0 immediately.
//     -> A stray iACC_fin after reset is ignored.

Source files
------------

// File: rtl/periph_pkg.sv
// Shared types and constants for the peripheral launch controller.
package periph_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    C_START = 3'd1,
    C_WAIT  = 3'd2,
    C_DONE  = 3'd3,
    A_START = 3'd4,
    A_WAIT  = 3'd5,
    A_DONE  = 3'd6
  } state_t;

  localparam logic [1:0] BUF_NONE = 2'b00;
  localparam logic [1:0] BUF_CCD  = 2'b01;
  localparam logic [1:0] BUF_ACC  = 2'b10;

endpackage

// File: rtl/wd_counter.sv
// Saturating watchdog counter with a terminal-count flag at TMO_CYC-1.
module wd_counter #(
  parameter int TMO_W   = 20,
  parameter int TMO_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TMO_W-1:0] TC_VAL = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] MAX_VAL = '1;

  logic [TMO_W-1:0] count;

  // Count while enabled, hold at all-ones; clear wins over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != MAX_VAL)) begin
      count <= count + TMO_W'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/periph_launch_ctrl.sv
// Launch sequencer for the CCD and the neural accelerator; owns the shared
// frame buffer grant and turns CPU request levels into start pulses.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  IDLE    | no peripheral active, buffer free; CCD request has priority
//  C_START | one cycle: issue CCD start pulse, grant buffer, clear watchdog
//  C_WAIT  | CCD running; wait for fin or watchdog terminal count
//  C_DONE  | CCD complete, buffer released; hold done until CPU drops en
//  A_START | one cycle: issue ACC start pulse, grant buffer, clear watchdog
//  A_WAIT  | ACC running; wait for fin or watchdog terminal count
//  A_DONE  | ACC complete, buffer released; hold done until CPU drops en
//
// Output registers are loaded from the current state and inputs, so a state
// entered on edge N shows its outputs from edge N+1 (start pulse two cycles
// after the request), while completion and release appear one cycle after fin.
module periph_launch_ctrl
  import periph_pkg::*;
#(
  parameter int TMO_W   = 20,
  parameter int TMO_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iCCD_en,
  input  logic       iACC_en,
  output logic       oCCD_done,
  output logic       oACC_done,
  output logic       oCCD_start,
  input  logic       iCCD_fin,
  output logic       oACC_start,
  input  logic       iACC_fin,
  output logic [1:0] oBufOwner,
  output logic       oErr,
  input  logic       iErrClr
);

  state_t     state, state_nxt;
  logic       ccd_start_nxt, acc_start_nxt;
  logic       ccd_done_nxt, acc_done_nxt;
  logic [1:0] owner_nxt;
  logic       err_set;
  logic       wd_clr, wd_en, wd_tc;

  wd_counter #(
    .TMO_W  (TMO_W),
    .TMO_CYC(TMO_CYC)
  ) u_wd (
    .clk(clk),
    .rst(rst),
    .clr(wd_clr),
    .en (wd_en),
    .tc (wd_tc)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_nxt     = state;
    ccd_start_nxt = 1'b0;
    acc_start_nxt = 1'b0;
    ccd_done_nxt  = 1'b0;
    acc_done_nxt  = 1'b0;
    owner_nxt     = BUF_NONE;
    err_set       = 1'b0;
    wd_clr        = 1'b0;
    wd_en         = 1'b0;
    case (state)
      IDLE: begin
        if (iCCD_en) state_nxt = C_START;
        else if (iACC_en) state_nxt = A_START;
      end
      C_START: begin
        ccd_start_nxt = 1'b1;
        owner_nxt     = BUF_CCD;
        wd_clr        = 1'b1;
        state_nxt     = C_WAIT;
      end
      C_WAIT: begin
        wd_en     = 1'b1;
        owner_nxt = BUF_CCD;
        // A timeout completes the handshake like a fin so the CPU never hangs;
        // a real fin on the terminal-count cycle is not an error.
        if (iCCD_fin || wd_tc) begin
          owner_nxt = BUF_NONE;
          err_set   = !iCCD_fin;
          if (iCCD_en) begin
            ccd_done_nxt = 1'b1;
            state_nxt    = C_DONE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      C_DONE: begin
        if (iCCD_en) ccd_done_nxt = 1'b1;
        else state_nxt = IDLE;
      end
      A_START: begin
        acc_start_nxt = 1'b1;
        owner_nxt     = BUF_ACC;
        wd_clr        = 1'b1;
        state_nxt     = A_WAIT;
      end
      A_WAIT: begin
        wd_en     = 1'b1;
        owner_nxt = BUF_ACC;
        if (iACC_fin || wd_tc) begin
          owner_nxt = BUF_NONE;
          err_set   = !iACC_fin;
          if (iACC_en) begin
            acc_done_nxt = 1'b1;
            state_nxt    = A_DONE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      A_DONE: begin
        if (iACC_en) acc_done_nxt = 1'b1;
        else state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      oCCD_start <= 1'b0;
      oACC_start <= 1'b0;
      oCCD_done  <= 1'b0;
      oACC_done  <= 1'b0;
      oBufOwner  <= BUF_NONE;
    end else begin
      state      <= state_nxt;
      oCCD_start <= ccd_start_nxt;
      oACC_start <= acc_start_nxt;
      oCCD_done  <= ccd_done_nxt;
      oACC_done  <= acc_done_nxt;
      oBufOwner  <= owner_nxt;
    end
  end

  // Sticky timeout flag; a clear request beats a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oErr <= 1'b0;
    end else if (iErrClr) begin
      oErr <= 1'b0;
    end else if (err_set) begin
      oErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_periph_launch_ctrl.sv
// Directed bench for periph_launch_ctrl with a short watchdog (16 cycles).
// Cycle c means the interval after the c-th rising edge since the test began.
module tb_periph_launch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       iCCD_en, iACC_en, iCCD_fin, iACC_fin, iErrClr;
  logic       oCCD_done, oACC_done, oCCD_start, oACC_start, oErr;
  logic [1:0] oBufOwner;

  int n_chk = 0;
  int n_err = 0;

  periph_launch_ctrl #(
    .TMO_W  (20),
    .TMO_CYC(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .iCCD_en   (iCCD_en),
    .iACC_en   (iACC_en),
    .oCCD_done (oCCD_done),
    .oACC_done (oACC_done),
    .oCCD_start(oCCD_start),
    .iCCD_fin  (iCCD_fin),
    .oACC_start(oACC_start),
    .iACC_fin  (iACC_fin),
    .oBufOwner (oBufOwner),
    .oErr      (oErr),
    .iErrClr   (iErrClr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ccd_start"}, oCCD_start, 0);
    chk({tag, "_acc_start"}, oACC_start, 0);
    chk({tag, "_ccd_done"},  oCCD_done,  0);
    chk({tag, "_acc_done"},  oACC_done,  0);
    chk({tag, "_owner"},     oBufOwner,  0);
    chk({tag, "_err"},       oErr,       0);
  endtask

  initial begin
    rst = 1'b1;
    iCCD_en = 0; iACC_en = 0; iCCD_fin = 0; iACC_fin = 0; iErrClr = 0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // 1: single CCD capture, fin at 10, en drop at 15
    iCCD_en = 1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      iCCD_fin = 0;
      chk("t1_start", oCCD_start, (c == 2));
      chk("t1_owner", oBufOwner, (c >= 2 && c <= 10) ? 1 : 0);
      chk("t1_done",  oCCD_done, (c >= 11 && c <= 15));
      chk("t1_acc_start", oACC_start, 0);
      if (c == 10) iCCD_fin = 1;
      if (c == 15) iCCD_en = 0;
    end
    chk("t1_err", oErr, 0);

    // 2: both requests together; CCD first, ACC follows without CPU action
    iCCD_en = 1;
    iACC_en = 1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      iCCD_fin = 0;
      iACC_fin = 0;
      chk("t2_ccd_start", oCCD_start, (c == 2));
      chk("t2_acc_start", oACC_start, (c == 11));
      chk("t2_owner", oBufOwner,
          (c >= 2 && c <= 5) ? 1 : ((c >= 11 && c <= 14) ? 2 : 0));
      chk("t2_ccd_done", oCCD_done, (c >= 6 && c <= 8));
      chk("t2_acc_done", oACC_done, (c == 15));
      if (c == 5) iCCD_fin = 1;
      if (c == 8) iCCD_en = 0;
      if (c == 14) iACC_fin = 1;
      if (c == 15) iACC_en = 0;
    end
    chk("t2_err", oErr, 0);

    // 3: ACC timeout with no fin; done and err at cycle 18, then clear err
    iACC_en = 1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk("t3_err",   oErr,      (c >= 18));
      chk("t3_done",  oACC_done, (c >= 18));
      chk("t3_owner", oBufOwner, (c >= 2 && c <= 17) ? 2 : 0);
    end
    iErrClr = 1;
    tick();
    iErrClr = 0;
    chk("t3_err_clr", oErr, 0);
    chk("t3_done_hold", oACC_done, 1);
    iACC_en = 0;
    tick();
    chk("t3_done_low", oACC_done, 0);
    tick();

    // 4: CCD fin lands exactly on the terminal-count cycle
    iCCD_en = 1;
    for (int c = 1; c <= 19; c++) begin
      tick();
      iCCD_fin = 0;
      chk("t4_err",  oErr,      0);
      chk("t4_done", oCCD_done, (c >= 18));
      if (c == 17) iCCD_fin = 1;
    end
    iCCD_en = 0;
    tick();
    chk("t4_done_low", oCCD_done, 0);

    // 5: CCD en dropped mid-wait; fin returns to IDLE without done.
    //    ACC request at 12 then starts at 14, proving the FSM is idle.
    iCCD_en = 1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      iCCD_fin = 0;
      chk("t5_ccd_start", oCCD_start, (c == 2));
      chk("t5_ccd_done",  oCCD_done,  0);
      chk("t5_acc_start", oACC_start, (c == 14));
      chk("t5_owner", oBufOwner,
          (c >= 2 && c <= 8) ? 1 : ((c >= 14) ? 2 : 0));
      chk("t5_err", oErr, 0);
      if (c == 5) iCCD_en = 0;
      if (c == 8) iCCD_fin = 1;
      if (c == 12) iACC_en = 1;
    end

    // 6: reset during A_WAIT clears everything at once; stray fin ignored
    rst = 1'b1;
    #1;
    chk_all_zero("t6_rst");
    iACC_en = 0;
    tick();
    rst = 1'b0;
    tick();
    iACC_fin = 1;
    tick();
    iACC_fin = 0;
    chk_all_zero("t6_stray");
    tick();
    tick();
    chk_all_zero("t6_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
